// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, single-outstanding IMEM handshake, instruction FIFO
module instr_fetch #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic [ADDR_WIDTH-1:0]  boot_addr_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  input  logic                   imem_ack_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  input  logic                   instr_ready_i
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(2);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_STALL = 2'd2
  } state_e;

  state_e                 state_q;
  // pc_q is the address presented on IMEM; it only moves once the current request is acked
  logic [ADDR_WIDTH-1:0]  pc_q;
  // redirect target parked here while the stale request drains
  logic [ADDR_WIDTH-1:0]  pend_pc_q;
  logic                   discard_q;
  logic                   req_q;

  logic [INSTR_WIDTH-1:0] mem_instr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  mem_pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;

  logic                   fetch_active;
  logic                   flush;
  logic                   ack_hit;
  logic                   push;
  logic                   pop;
  logic                   fifo_nonempty;
  logic [ADDR_WIDTH-1:0]  redirect_target;

  assign fetch_active    = (state_q != S_BOOT);
  assign flush           = redirect_i & fetch_active;
  assign ack_hit         = req_q & imem_ack_i;
  assign push            = ack_hit & ~discard_q & ~redirect_i;
  assign fifo_nonempty   = (count_q != '0);
  assign pop             = fifo_nonempty & instr_ready_i & ~flush;
  assign redirect_target = redirect_addr_i & ALIGN_MASK;

  // occupancy after this edge; flush wins over push and pop
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // fetch FSM: owns the PC, the request flag and the discard flag for a redirected in-flight request
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= S_BOOT;
      pc_q      <= '0;
      pend_pc_q <= '0;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q   <= S_REQ;
          req_q     <= 1'b1;
          pc_q      <= boot_addr_i & ALIGN_MASK;
          discard_q <= 1'b0;
        end
        S_REQ: begin
          if (redirect_i) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            if (imem_ack_i) begin
              // request completes this edge, so the target can go out right away
              pc_q      <= redirect_target;
              discard_q <= 1'b0;
            end else begin
              // keep the old address stable until its ack arrives, then drop that ack
              pend_pc_q <= redirect_target;
              discard_q <= 1'b1;
            end
          end else if (imem_ack_i) begin
            if (discard_q) begin
              pc_q      <= pend_pc_q;
              discard_q <= 1'b0;
            end else begin
              pc_q <= pc_q + PC_STEP;
              if (count_d == FULL_CNT) begin
                state_q <= S_STALL;
                req_q   <= 1'b0;
              end
            end
          end
        end
        S_STALL: begin
          if (redirect_i) begin
            pc_q    <= redirect_target;
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end else if (count_d != FULL_CNT) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_BOOT;
          req_q     <= 1'b0;
          discard_q <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
      end
    end
  end

  // FIFO storage; contents are only visible through the occupancy-qualified head
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_instr_q[wr_ptr_q] <= imem_rdata_i;
      mem_pc_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = fifo_nonempty;
  assign instr_o       = fifo_nonempty ? mem_instr_q[rd_ptr_q] : '0;
  assign instr_pc_o    = fifo_nonempty ? mem_pc_q[rd_ptr_q] : '0;

endmodule
